// File: rtl/des_key_schedule_pkg.sv
// ============================================================================
// Module   : des_key_pkg
// Purpose  : Shared types and constants for the DES key-schedule front end.
//            Holds the state encoding, C||D widths, the per-round rotation
//            amounts (encrypt and decrypt order), the PC-1 bit-index table and
//            the 28-bit half rotation helpers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package des_key_pkg;

    localparam int KEY_W  = 64;
    localparam int CD_W   = 56;
    localparam int HALF_W = 28;

    // Explicitly encoded 1-bit state register.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Left-rotation applied to produce round r (encrypt order). Entry 0 is
    // folded into the key load, the rest are applied between rounds.
    localparam logic [1:0] SHIFT [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // Right-rotation applied to produce round r (decrypt order). Round 0 is
    // C0||D0 itself, which equals C16||D16 because the total rotation is 28.
    localparam logic [1:0] DSHIFT [16] = '{
        2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // PC-1: output bit i (1-based, MSB first) takes key bit PC1_TABLE[i-1],
    // both in DES numbering where bit 1 is the MSB.
    localparam int PC1_TABLE [CD_W] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    function automatic logic [HALF_W-1:0] rotl28(input logic [HALF_W-1:0] x,
                                                 input logic [1:0]        amt);
        logic [HALF_W-1:0] r;
        case (amt)
            2'd1:    r = {x[HALF_W-2:0], x[HALF_W-1]};
            2'd2:    r = {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]};
            default: r = x;
        endcase
        return r;
    endfunction

    function automatic logic [HALF_W-1:0] rotr28(input logic [HALF_W-1:0] x,
                                                 input logic [1:0]        amt);
        logic [HALF_W-1:0] r;
        case (amt)
            2'd1:    r = {x[0], x[HALF_W-1:1]};
            2'd2:    r = {x[1:0], x[HALF_W-1:2]};
            default: r = x;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/des_key_schedule_if.sv
// ============================================================================
// Module   : des_key_schedule_if
// Purpose  : Key-input and C||D-output handshake bundle of des_key_schedule.
//            slave  : the key-schedule block side
//            master : the key source / round consumer side
// Signals  : key_in, decrypt, key_valid, key_ready, abort,
//            cd_out, round_idx, cd_valid, cd_ready, done
//            parity_err (only when KEY_PARITY_CHECK_EN is defined)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface des_key_schedule_if #(
    parameter int CNT_W = 4
);
    import des_key_pkg::*;

    logic [KEY_W-1:0] key_in;
    logic             decrypt;
    logic             key_valid;
    logic             key_ready;
    logic             abort;
    logic [CD_W-1:0]  cd_out;
    logic [CNT_W-1:0] round_idx;
    logic             cd_valid;
    logic             cd_ready;
    logic             done;
`ifdef KEY_PARITY_CHECK_EN
    logic             parity_err;

    modport slave (
        input  key_in, decrypt, key_valid, abort, cd_ready,
        output key_ready, cd_out, round_idx, cd_valid, done, parity_err
    );

    modport master (
        output key_in, decrypt, key_valid, abort, cd_ready,
        input  key_ready, cd_out, round_idx, cd_valid, done, parity_err
    );
`else
    modport slave (
        input  key_in, decrypt, key_valid, abort, cd_ready,
        output key_ready, cd_out, round_idx, cd_valid, done
    );

    modport master (
        output key_in, decrypt, key_valid, abort, cd_ready,
        input  key_ready, cd_out, round_idx, cd_valid, done
    );
`endif

endinterface

`default_nettype wire

// File: rtl/des_key_schedule_pc1.sv
// ============================================================================
// Module   : permuted_choice_1
// Purpose  : Pure combinational DES PC-1, 64-bit key -> 56-bit C||D.
//            The eight parity bits (DES bits 8,16,..,64) are discarded.
// Ports    : i_key [63:0]  key, DES bit 1 at index 63
//            o_cd  [55:0]  C||D, C in [55:28]
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module permuted_choice_1
    import des_key_pkg::*;
(
    input  wire logic [KEY_W-1:0] i_key,
    output logic      [CD_W-1:0]  o_cd
);

    // DES bit n lives at vector index KEY_W-n.
    for (genvar i = 0; i < CD_W; i++) begin : g_pc1
        assign o_cd[CD_W-1-i] = i_key[KEY_W-PC1_TABLE[i]];
    end

    // Parity bits are intentionally not part of C||D.
    logic [7:0] w_unused_parity;
    for (genvar b = 0; b < 8; b++) begin : g_parity_sink
        assign w_unused_parity[b] = i_key[8*b];
    end

endmodule

`default_nettype wire

// File: rtl/des_key_schedule.sv
// ============================================================================
// Module   : des_key_schedule
// Purpose  : Sequential DES key-schedule front end. Takes one 64-bit key,
//            applies PC-1 and streams the 16 rotated C||D words (one per
//            round) in encrypt order K1..K16 or decrypt order K16..K1.
// Ports    : clk, rst (synchronous, active high)
//            bus : des_key_schedule_if.slave
//              key_in/decrypt/key_valid/key_ready : key acceptance
//              abort                              : drop schedule, go idle
//              cd_out/round_idx/cd_valid/cd_ready : round word stream
//              done                               : pulse after last round
//              parity_err                         : with KEY_PARITY_CHECK_EN
// Config   : KEY_PARITY_CHECK_EN - adds parity_err, set at key accept when
//            any key byte has even parity.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module des_key_schedule
    import des_key_pkg::*;
#(
    parameter int ROUNDS = 16,
    parameter int CNT_W  = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    des_key_schedule_if.slave bus
);

    if (ROUNDS != 16) begin : g_bad_rounds
        $error("des_key_schedule: ROUNDS must be 16");
    end

    state_t           r_state;
    state_t           w_state_next;
    logic [CD_W-1:0]  r_cd;
    logic [CNT_W-1:0] r_round;
    logic             r_cd_valid;
    logic             r_done;
    logic             r_decrypt;

    logic [CD_W-1:0]   w_pc1;
    logic [CD_W-1:0]   w_cd_load;
    logic [CD_W-1:0]   w_cd_adv;
    logic [HALF_W-1:0] w_c_pc1;
    logic [HALF_W-1:0] w_d_pc1;
    logic [HALF_W-1:0] w_c_cur;
    logic [HALF_W-1:0] w_d_cur;
    logic [CNT_W-1:0]  w_round_next;
    logic              w_key_ready;
    logic              w_accept;
    logic              w_handshake;
    logic              w_last;

    permuted_choice_1 u_pc1 (
        .i_key (bus.key_in),
        .o_cd  (w_pc1)
    );

    assign w_key_ready  = (r_state == IDLE) & ~rst;
    assign w_accept     = bus.key_valid & w_key_ready;
    assign w_handshake  = r_cd_valid & bus.cd_ready;
    assign w_last       = (r_round == CNT_W'(ROUNDS - 1));
    assign w_round_next = r_round + CNT_W'(1);

    assign w_c_pc1 = w_pc1[CD_W-1:HALF_W];
    assign w_d_pc1 = w_pc1[HALF_W-1:0];
    assign w_c_cur = r_cd[CD_W-1:HALF_W];
    assign w_d_cur = r_cd[HALF_W-1:0];

    // Encrypt starts at C1||D1, decrypt starts at C16||D16 == C0||D0.
    assign w_cd_load = bus.decrypt ? w_pc1
                                   : {rotl28(w_c_pc1, SHIFT[0]),
                                      rotl28(w_d_pc1, SHIFT[0])};

    // Rotation amount is looked up for the round about to be presented.
    assign w_cd_adv = r_decrypt ? {rotr28(w_c_cur, DSHIFT[w_round_next]),
                                   rotr28(w_d_cur, DSHIFT[w_round_next])}
                                : {rotl28(w_c_cur, SHIFT[w_round_next]),
                                   rotl28(w_d_cur, SHIFT[w_round_next])};

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept)               w_state_next = RUN;
            RUN:     if (w_handshake && w_last)  w_state_next = IDLE;
            default:                             w_state_next = IDLE;
        endcase
        // abort wins over any accept or final handshake in the same cycle.
        if (bus.abort) begin
            w_state_next = IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Datapath: C||D register, round counter, valid and done
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cd       <= '0;
            r_round    <= '0;
            r_cd_valid <= 1'b0;
            r_done     <= 1'b0;
            r_decrypt  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (bus.abort) begin
                r_cd_valid <= 1'b0;
                r_round    <= '0;
            end else if (w_accept) begin
                r_cd       <= w_cd_load;
                r_round    <= '0;
                r_cd_valid <= 1'b1;
                r_decrypt  <= bus.decrypt;
            end else if ((r_state == RUN) && w_handshake) begin
                if (w_last) begin
                    r_cd_valid <= 1'b0;
                    r_round    <= '0;
                    r_done     <= 1'b1;
                end else begin
                    r_round <= w_round_next;
                    r_cd    <= w_cd_adv;
                end
            end
        end
    end

    assign bus.key_ready = w_key_ready;
    assign bus.cd_out    = r_cd;
    assign bus.round_idx = r_round;
    assign bus.cd_valid  = r_cd_valid;
    assign bus.done      = r_done;

`ifdef KEY_PARITY_CHECK_EN
    logic [7:0] w_byte_even;
    logic       r_parity_err;

    // DES key bytes must have odd parity; flag any byte with even parity.
    for (genvar b = 0; b < 8; b++) begin : g_parity
        assign w_byte_even[b] = ~^bus.key_in[8*b +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity_err <= 1'b0;
        end else if (w_accept && !bus.abort) begin
            r_parity_err <= |w_byte_even;
        end
    end

    assign bus.parity_err = r_parity_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_des_key_schedule.sv
// ============================================================================
// Module   : tb_des_key_schedule
// Purpose  : Self-checking bench for des_key_schedule. Table-driven known
//            vectors, randomized schedules with backpressure and key_valid
//            noise, and hand sequences for reset, stall, abort and rst.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_des_key_schedule;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    des_key_schedule_if #(.CNT_W(4)) bus ();

    des_key_schedule #(.ROUNDS(16), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef logic [55:0] words_t [16];

    typedef struct {
        logic [63:0] key;
        logic        dec;
        logic        has_const;
        logic [27:0] c0, d0, c15, d15;
    } vec_t;

    localparam int PC1_REF [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int SHIFT_REF [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [55:0] pc1_ref(input logic [63:0] k);
        logic [55:0] r;
        for (int i = 0; i < 56; i++) r[55-i] = k[64-PC1_REF[i]];
        return r;
    endfunction

    function automatic logic [27:0] rot28(input logic [27:0] x, input int n);
        logic [55:0] t;
        t = {x, x} << (n % 28);
        return t[55:28];
    endfunction

    // Round r of encrypt order is C0/D0 rotated left by the cumulative shift;
    // decrypt order is the same list reversed.
    function automatic words_t sched_ref(input logic [63:0] k, input logic dec);
        words_t enc, res;
        logic [55:0] cd0;
        int total;
        cd0 = pc1_ref(k);
        total = 0;
        for (int r = 0; r < 16; r++) begin
            total += SHIFT_REF[r];
            enc[r] = {rot28(cd0[55:28], total), rot28(cd0[27:0], total)};
        end
        for (int r = 0; r < 16; r++) res[r] = dec ? enc[15-r] : enc[r];
        return res;
    endfunction

    function automatic logic parity_ref(input logic [63:0] k);
        logic bad;
        bad = 1'b0;
        for (int b = 0; b < 8; b++) begin
            int ones;
            ones = 0;
            for (int i = 0; i < 8; i++) ones += int'(k[8*b+i]);
            if (ones % 2 == 0) bad = 1'b1;
        end
        return bad;
    endfunction

    // Full schedule: accept key, collect 16 words with random backpressure,
    // optional key_valid noise during RUN, then check done pulse.
    task automatic run_schedule(input logic [63:0] key, input logic dec,
                                input int bp_pct, input logic noise,
                                output logic [55:0] w0, output logic [55:0] w15);
        words_t exp;
        int idx;
        int guard;
        exp = sched_ref(key, dec);
        idx = 0;
        guard = 0;
        w0 = '0;
        w15 = '0;
        bus.key_in = key;
        bus.decrypt = dec;
        bus.key_valid = 1'b1;
        bus.cd_ready = 1'b0;
        check("key_ready_idle", bus.key_ready, 1);
        tick();
        bus.key_valid = 1'b0;
        check("latency1_valid", bus.cd_valid, 1);
`ifdef KEY_PARITY_CHECK_EN
        check("parity_err", bus.parity_err, parity_ref(key));
`endif
        while (idx < 16 && guard < 400) begin
            logic rdy;
            rdy = ($urandom_range(99) >= bp_pct);
            if (noise) begin
                bus.key_valid = 1'($urandom_range(1));
                bus.key_in = {$urandom, $urandom};
                bus.decrypt = 1'($urandom_range(1));
            end
            check("key_ready_run", bus.key_ready, 0);
            check("cd_valid_run", bus.cd_valid, 1);
            check("round_idx", bus.round_idx, idx);
            check("cd_out", bus.cd_out, exp[idx]);
            if (idx == 0) w0 = bus.cd_out;
            if (idx == 15) w15 = bus.cd_out;
            bus.cd_ready = rdy;
            tick();
            if (rdy) idx++;
            guard++;
        end
        bus.key_valid = 1'b0;
        bus.cd_ready = 1'b0;
        check("schedule_complete", idx, 16);
        check("done_pulse", bus.done, 1);
        check("end_cd_valid", bus.cd_valid, 0);
        check("end_round_idx", bus.round_idx, 0);
        check("end_key_ready", bus.key_ready, 1);
`ifdef KEY_PARITY_CHECK_EN
        check("parity_err_held", bus.parity_err, parity_ref(key));
`endif
        tick();
        check("done_one_cycle", bus.done, 0);
    endtask

    // Bring a fresh schedule up to a given round with cd_ready high.
    task automatic start_and_advance(input logic [63:0] key, input int target);
        int guard;
        bus.key_in = key;
        bus.decrypt = 1'b0;
        bus.key_valid = 1'b1;
        bus.cd_ready = 1'b0;
        tick();
        bus.key_valid = 1'b0;
        bus.cd_ready = 1'b1;
        guard = 0;
        while (int'(bus.round_idx) != target && guard < 40) begin
            tick();
            guard++;
        end
        bus.cd_ready = 1'b0;
        check("advance_reached", bus.round_idx, target);
    endtask

    localparam logic [27:0] E_C0  = 28'b1110000110011001010101011111;
    localparam logic [27:0] E_D0  = 28'b1010101011001100111100011110;
    localparam logic [27:0] E_C15 = 28'b1111000011001100101010101111;
    localparam logic [27:0] E_D15 = 28'b0101010101100110011110001111;

    initial begin
        vec_t vecs [4];
        words_t exp;
        logic [55:0] w0, w15;
        int hs, dones, stall, cyc;

        vecs[0] = '{key: 64'h133457799BBCDFF1, dec: 1'b0, has_const: 1'b1,
                    c0: E_C0, d0: E_D0, c15: E_C15, d15: E_D15};
        vecs[1] = '{key: 64'h133457799BBCDFF1, dec: 1'b1, has_const: 1'b1,
                    c0: E_C15, d0: E_D15, c15: E_C0, d15: E_D0};
        vecs[2] = '{key: 64'h0123456789ABCDEF, dec: 1'b0, has_const: 1'b0,
                    c0: '0, d0: '0, c15: '0, d15: '0};
        vecs[3] = '{key: 64'h0123456789ABCDEE, dec: 1'b1, has_const: 1'b0,
                    c0: '0, d0: '0, c15: '0, d15: '0};

        rst = 1'b1;
        bus.key_in = '0;
        bus.decrypt = 1'b0;
        bus.key_valid = 1'b0;
        bus.abort = 1'b0;
        bus.cd_ready = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_cd_valid", bus.cd_valid, 0);
        check("rst_done", bus.done, 0);
        check("rst_round_idx", bus.round_idx, 0);
        check("rst_cd_out", bus.cd_out, 0);
        check("rst_key_ready", bus.key_ready, 0);
        rst = 1'b0;
        tick();
        check("post_rst_key_ready", bus.key_ready, 1);

        // Known vectors
        for (int v = 0; v < 4; v++) begin
            run_schedule(vecs[v].key, vecs[v].dec, 0, 1'b0, w0, w15);
            if (vecs[v].has_const) begin
                check("vec_round0", w0, {vecs[v].c0, vecs[v].d0});
                check("vec_round15", w15, {vecs[v].c15, vecs[v].d15});
            end
        end

        // Backpressure: stall 3 cycles at round 4
        exp = sched_ref(64'h133457799BBCDFF1, 1'b0);
        bus.key_in = 64'h133457799BBCDFF1;
        bus.decrypt = 1'b0;
        bus.key_valid = 1'b1;
        tick();
        bus.key_valid = 1'b0;
        hs = 0; dones = 0; stall = 0; cyc = 0;
        while (cyc < 40) begin
            if (bus.done) dones++;
            if (bus.cd_valid) begin
                if (bus.round_idx == 4'd4 && stall < 3) begin
                    bus.cd_ready = 1'b0;
                    stall++;
                    check("bp_hold_idx", bus.round_idx, 4);
                    check("bp_hold_cd", bus.cd_out, exp[4]);
                end else begin
                    bus.cd_ready = 1'b1;
                    check("bp_cd_out", bus.cd_out, exp[bus.round_idx]);
                    hs++;
                end
            end else begin
                bus.cd_ready = 1'b0;
            end
            tick();
            cyc++;
        end
        check("bp_handshakes", hs, 16);
        check("bp_done_count", dones, 1);
        check("bp_stall_cycles", stall, 3);

        // Abort at round 7 with key_valid also asserted
        start_and_advance(64'h133457799BBCDFF1, 7);
        bus.abort = 1'b1;
        bus.key_valid = 1'b1;
        bus.key_in = 64'h0E329232EA6D0D73;
        bus.decrypt = 1'b1;
        tick();
        check("abort_cd_valid", bus.cd_valid, 0);
        check("abort_round_idx", bus.round_idx, 0);
        check("abort_done", bus.done, 0);
        check("abort_key_ready", bus.key_ready, 1);
        // abort in IDLE with key_valid: key still not taken
        tick();
        check("abort_idle_no_accept", bus.cd_valid, 0);
        bus.abort = 1'b0;
        tick();
        bus.key_valid = 1'b0;
        exp = sched_ref(64'h0E329232EA6D0D73, 1'b1);
        check("restart_valid", bus.cd_valid, 1);
        check("restart_round_idx", bus.round_idx, 0);
        check("restart_cd_out", bus.cd_out, exp[0]);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;

        // rst mid-schedule clears everything including cd_out
        start_and_advance(64'hFEDCBA9876543210, 3);
        rst = 1'b1;
        tick();
        check("midrst_cd_out", bus.cd_out, 0);
        check("midrst_cd_valid", bus.cd_valid, 0);
        check("midrst_round_idx", bus.round_idx, 0);
        check("midrst_key_ready", bus.key_ready, 0);
        rst = 1'b0;
        tick();

        // Randomized schedules with backpressure and key_valid noise
        for (int n = 0; n < 8; n++) begin
            run_schedule({$urandom, $urandom}, 1'($urandom_range(1)), 35, 1'b1, w0, w15);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
